// File: rtl/run_detector_if.sv
// Signal bundle for run_detector: sample/control inputs and the detection outputs.
// The master side drives samples; the slave side is the detector itself.
interface run_detector_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int CW = $clog2(N + 1);

    logic          en;
    logic          w;
    logic          mode;
    logic          clr_cnt;
    logic          z;
    logic          z0;
    logic          z1;
    logic [CW-1:0] run_len;
    logic [1:0]    stan;
    logic [DW-1:0] det_cnt;

    modport master (
        output en, w, mode, clr_cnt,
        input  z, z0, z1, run_len, stan, det_cnt
    );

    modport slave (
        input  en, w, mode, clr_cnt,
        output z, z0, z1, run_len, stan, det_cnt
    );
endinterface

// File: rtl/run_detector.sv
// Detects N consecutive equal bits on a gated serial stream (level or pulse mode)
// and keeps a saturating count of detection events.
module run_detector #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            aclr,
    run_detector_if.slave   bus
);
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] N_C   = CW'(N);
    localparam logic [CW-1:0] N_M1  = CW'(N - 1);
    localparam logic [DW-1:0] DET_MAX = {DW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN0 = 2'b01,
        RUN1 = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] det_cnt_q, det_cnt_d;
    logic          det_event;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            det_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            det_cnt_q <= det_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        det_event = 1'b0;
        if (bus.en) begin
            case (state_q)
                RUN0, RUN1: begin
                    if (bus.w != (state_q == RUN1)) begin
                        state_d = bus.w ? RUN1 : RUN0;
                        cnt_d   = ONE;
                    end else if (cnt_q < N_C) begin
                        cnt_d     = cnt_q + ONE;
                        det_event = (cnt_q == N_M1);
                    end else begin
                        // Full run: level mode holds at N, pulse mode starts a fresh group
                        cnt_d = bus.mode ? ONE : N_C;
                    end
                end
                default: begin
                    state_d = bus.w ? RUN1 : RUN0;
                    cnt_d   = ONE;
                end
            endcase
        end

        det_cnt_d = det_cnt_q;
        if (bus.clr_cnt) begin
            det_cnt_d = '0;
        end else if (det_event && (det_cnt_q != DET_MAX)) begin
            det_cnt_d = det_cnt_q + DW'(1);
        end
    end

    always_comb begin
        bus.z0      = (state_q == RUN0) && (cnt_q == N_C);
        bus.z1      = (state_q == RUN1) && (cnt_q == N_C);
        bus.z       = bus.z0 | bus.z1;
        bus.run_len = cnt_q;
        bus.stan    = state_q;
        bus.det_cnt = det_cnt_q;
    end
endmodule

// File: doc/run_detector.md
RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 SHALL have parameter N, default 4, meaning the run length to detect; legal range 2..255.
REQ-002 SHALL have parameter DW, default 8, meaning the width of the detection-event counter.
REQ-003 SHALL derive localparam CW = clog2(N+1), meaning the width of run_len.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port aclr, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port en, input, 1, the sample enable; w is consumed only on edges where en=1.
REQ-007 SHALL have port w, input, 1, the serial data bit.
REQ-008 SHALL have port mode, input, 1: 0 = level (hold detection while the run continues), 1 = pulse (restart count after each detection).
REQ-009 SHALL have port clr_cnt, input, 1, a synchronous clear of det_cnt.
REQ-010 SHALL have port z, output, 1, meaning z0 | z1.
REQ-011 SHALL have port z0, output, 1, meaning N consecutive zeros detected.
REQ-012 SHALL have port z1, output, 1, meaning N consecutive ones detected.
REQ-013 SHALL have port run_len, output, CW, meaning the current run length, 0..N.
REQ-014 SHALL have port stan, output, 2, meaning the FSM state code: IDLE=00, RUN0=01, RUN1=10.
REQ-015 SHALL have port det_cnt, output, DW, meaning the number of detection events, saturating.

Function
REQ-016 SHALL implement FSM states IDLE, RUN0 and RUN1 plus a CW-bit counter cnt; run_len = cnt.
REQ-017 SHALL hold all state, cnt and det_cnt unchanged on edges with en=0 (clr_cnt excepted).
REQ-018 SHALL, from IDLE with en=1, go to RUN0 with cnt=1 on w=0, or to RUN1 with cnt=1 on w=1.
REQ-019 SHALL, in RUN0 on w=1 or in RUN1 on w=0, switch to the opposite RUN state with cnt=1.
REQ-020 SHALL, in RUN0/RUN1 on the same bit with cnt<N, increment cnt by 1.
REQ-021 SHALL, on the same bit with cnt==N, hold cnt at N when mode=0, or set cnt to 1 when mode=1.
REQ-022 SHALL never return to IDLE except via reset.
REQ-023 SHALL drive outputs as Moore outputs from registered state only: z0=(RUN0 && cnt==N), z1=(RUN1 && cnt==N).
REQ-024 SHALL count a detection event on an edge where en=1 and cnt changes from N-1 to N.
REQ-025 SHALL increment det_cnt by 1 per detection event, saturating at 2^DW-1 without wrapping.
REQ-026 SHALL clear det_cnt to 0 on an edge with clr_cnt=1, regardless of en; clr_cnt takes priority over a simultaneous event, which is then lost.
REQ-027 SHALL give mode, when changed mid-run, effect on the next enabled edge only, with no retroactive change to cnt.
REQ-028 SHALL, in mode=1, produce one z pulse (one enabled sample wide) every N same-bit samples of an unbroken run.
REQ-029 SHALL give a detection a latency of 0 cycles after the edge that samples the Nth bit; z is valid immediately after that edge.

Reset
REQ-030 SHALL, while aclr=0, asynchronously force state IDLE, cnt=0, det_cnt=0, and therefore z=z0=z1=0, run_len=0, stan=00.
REQ-031 SHALL, on reset asserted mid-run, discard the run immediately, so that counting restarts from IDLE on the first enabled edge after release.
REQ-032 SHALL, on the first edge after aclr deassertion, behave per REQ-018 if en=1.

Verification
REQ-033 SHALL verify: N=4, mode=0, en=1, w=0000000 -> z0 rises after 4th edge, stays 1 through 7th, run_len=4, det_cnt=1.
REQ-034 SHALL verify: N=4, mode=1, w=1 for 9 edges -> z1=1 after edges 4 and 8 only, det_cnt=2, run_len sequence 1,2,3,4,1,2,3,4,1.
REQ-035 SHALL verify: w=0001 0000 -> z0 never asserts on the first run; run_len goes 1,2,3 then 1 (RUN1) then 1..4 (RUN0); z0=1 after the last edge.
REQ-036 SHALL verify: w=0 with en toggling 1,0,1,0,1,0,1 -> z0 asserts only after the 4th enabled edge; state frozen on en=0 edges.
REQ-037 SHALL verify: DW=2, mode=1, w=1 for 20 edges -> det_cnt saturates at 3; a clr_cnt=1 edge coinciding with an event gives det_cnt=0.
REQ-038 SHALL verify: aclr pulsed low between edges during a run with run_len=3 -> outputs go to 0/IDLE immediately without a clock; post-release w=0000 gives z0 after the 4th edge.
